// File: rtl/fft.sv
// fft: 8-point fully parallel radix-2 DIT FFT, three registered butterfly stages, natural-order I/O.
// Define FFT_SAT_EN to saturate, rather than wrap, when narrowing to the output integer width.
module fft #(
   parameter int N                    = 8,
   parameter int INPUT_WORD_WIDTH     = 12,
   parameter int INPUT_INTEGER_WIDTH  = 3,
   parameter int OUTPUT_WORD_WIDTH    = 12,
   parameter int OUTPUT_INTEGER_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [INPUT_WORD_WIDTH-1:0]  x0_real, x0_imag, x1_real, x1_imag,
   input  logic [INPUT_WORD_WIDTH-1:0]  x2_real, x2_imag, x3_real, x3_imag,
   input  logic [INPUT_WORD_WIDTH-1:0]  x4_real, x4_imag, x5_real, x5_imag,
   input  logic [INPUT_WORD_WIDTH-1:0]  x6_real, x6_imag, x7_real, x7_imag,
   output logic [OUTPUT_WORD_WIDTH-1:0] y0_real, y0_imag, y1_real, y1_imag,
   output logic [OUTPUT_WORD_WIDTH-1:0] y2_real, y2_imag, y3_real, y3_imag,
   output logic [OUTPUT_WORD_WIDTH-1:0] y4_real, y4_imag, y5_real, y5_imag,
   output logic [OUTPUT_WORD_WIDTH-1:0] y6_real, y6_imag, y7_real, y7_imag
);
   localparam int IW = INPUT_WORD_WIDTH;
   localparam int OW = OUTPUT_WORD_WIDTH;
   localparam int SH = (IW - INPUT_INTEGER_WIDTH) - (OW - OUTPUT_INTEGER_WIDTH);
   localparam int W1 = IW + 1;
   localparam int W2 = IW + 2;
   // One guard bit beyond the per-stage growth absorbs the sqrt(2) gain of the W1/W3 rotations.
   localparam int W3 = IW + 4;
   localparam int RW = W3 + 1;
   localparam int PW = W3 + 12;
   localparam logic signed [11:0]    CM   = 12'sd724;
   localparam logic signed [PW-1:0]  PRND = PW'(512);
   localparam logic signed [RW-1:0]  ORND = RW'((1 << SH) >> 1);
   localparam logic signed [RW-1:0]  OMAX = RW'((1 << (OW - 1)) - 1);
   localparam logic signed [RW-1:0]  OMIN = RW'(-(1 << (OW - 1)));
   localparam int BR [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   generate
      if (N != 8) begin : g_bad_n
         $error("fft: only N = 8 is supported");
      end
      if (SH < 0) begin : g_bad_frac
         $error("fft: output fraction wider than input fraction is not supported");
      end
   endgenerate

   logic signed [IW-1:0] xr [8], xi [8];
   logic signed [W1-1:0] s1_re_d [8], s1_im_d [8], s1_re_q [8], s1_im_q [8];
   logic signed [W2-1:0] s2_re_d [8], s2_im_d [8], s2_re_q [8], s2_im_q [8];
   logic signed [W3-1:0] t_re [4], t_im [4], d_re [8], d_im [8];
   logic [OW-1:0]        y_re_d [8], y_im_d [8], y_re_q [8], y_im_q [8];

   // Multiply by C = 724/1024 and round half-up back to the datapath fraction.
   function automatic logic signed [W3-1:0] twid(input logic signed [W3-1:0] s);
      logic signed [PW-1:0] p;
      p = PW'(s) * PW'(CM) + PRND;
      return W3'(p >>> 10);
   endfunction

   function automatic logic [OW-1:0] narrow(input logic signed [W3-1:0] v);
      logic signed [RW-1:0] r;
      r = (RW'(v) + ORND) >>> SH;
`ifdef FFT_SAT_EN
      if (r > OMAX) return OW'(OMAX);
      if (r < OMIN) return OW'(OMIN);
`endif
      return OW'(r);
   endfunction

   always_comb begin
      xr[0] = x0_real; xi[0] = x0_imag; xr[1] = x1_real; xi[1] = x1_imag;
      xr[2] = x2_real; xi[2] = x2_imag; xr[3] = x3_real; xi[3] = x3_imag;
      xr[4] = x4_real; xi[4] = x4_imag; xr[5] = x5_real; xi[5] = x5_imag;
      xr[6] = x6_real; xi[6] = x6_imag; xr[7] = x7_real; xi[7] = x7_imag;
   end

   // Stage 1: bit-reversed pairs, i.e. x[n] with x[n+4]; all twiddles are W0.
   always_comb begin
      for (int unsigned m = 0; m < 4; m++) begin
         s1_re_d[2*m]   = W1'(xr[BR[2*m]]) + W1'(xr[BR[2*m+1]]);
         s1_im_d[2*m]   = W1'(xi[BR[2*m]]) + W1'(xi[BR[2*m+1]]);
         s1_re_d[2*m+1] = W1'(xr[BR[2*m]]) - W1'(xr[BR[2*m+1]]);
         s1_im_d[2*m+1] = W1'(xi[BR[2*m]]) - W1'(xi[BR[2*m+1]]);
      end
   end

   // Stage 2: span 2, twiddles W0 and W2 = -j (swap and negate only).
   always_comb begin
      for (int unsigned h = 0; h < 2; h++) begin
         s2_re_d[4*h]   = W2'(s1_re_q[4*h]) + W2'(s1_re_q[4*h+2]);
         s2_im_d[4*h]   = W2'(s1_im_q[4*h]) + W2'(s1_im_q[4*h+2]);
         s2_re_d[4*h+2] = W2'(s1_re_q[4*h]) - W2'(s1_re_q[4*h+2]);
         s2_im_d[4*h+2] = W2'(s1_im_q[4*h]) - W2'(s1_im_q[4*h+2]);
         s2_re_d[4*h+1] = W2'(s1_re_q[4*h+1]) + W2'(s1_im_q[4*h+3]);
         s2_im_d[4*h+1] = W2'(s1_im_q[4*h+1]) - W2'(s1_re_q[4*h+3]);
         s2_re_d[4*h+3] = W2'(s1_re_q[4*h+1]) - W2'(s1_im_q[4*h+3]);
         s2_im_d[4*h+3] = W2'(s1_im_q[4*h+1]) + W2'(s1_re_q[4*h+3]);
      end
   end

   // Stage 3: span 1 with W0..W3, then output rounding/narrowing straight into the y registers.
   always_comb begin
      t_re[0] = W3'(s2_re_q[4]);
      t_im[0] = W3'(s2_im_q[4]);
      t_re[1] = twid(W3'(s2_re_q[5]) + W3'(s2_im_q[5]));
      t_im[1] = twid(W3'(s2_im_q[5]) - W3'(s2_re_q[5]));
      t_re[2] = W3'(s2_im_q[6]);
      t_im[2] = -W3'(s2_re_q[6]);
      t_re[3] = twid(W3'(s2_im_q[7]) - W3'(s2_re_q[7]));
      t_im[3] = twid(-(W3'(s2_re_q[7]) + W3'(s2_im_q[7])));
      for (int unsigned k = 0; k < 4; k++) begin
         d_re[k]   = W3'(s2_re_q[k]) + t_re[k];
         d_im[k]   = W3'(s2_im_q[k]) + t_im[k];
         d_re[k+4] = W3'(s2_re_q[k]) - t_re[k];
         d_im[k+4] = W3'(s2_im_q[k]) - t_im[k];
      end
      for (int unsigned k = 0; k < 8; k++) begin
         y_re_d[k] = narrow(d_re[k]);
         y_im_d[k] = narrow(d_im[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_re_q <= '{default: '0};
         s1_im_q <= '{default: '0};
         s2_re_q <= '{default: '0};
         s2_im_q <= '{default: '0};
         y_re_q  <= '{default: '0};
         y_im_q  <= '{default: '0};
      end else begin
         s1_re_q <= s1_re_d;
         s1_im_q <= s1_im_d;
         s2_re_q <= s2_re_d;
         s2_im_q <= s2_im_d;
         y_re_q  <= y_re_d;
         y_im_q  <= y_im_d;
      end
   end

   always_comb begin
      y0_real = y_re_q[0]; y0_imag = y_im_q[0]; y1_real = y_re_q[1]; y1_imag = y_im_q[1];
      y2_real = y_re_q[2]; y2_imag = y_im_q[2]; y3_real = y_re_q[3]; y3_imag = y_im_q[3];
      y4_real = y_re_q[4]; y4_imag = y_im_q[4]; y5_real = y_re_q[5]; y5_imag = y_im_q[5];
      y6_real = y_re_q[6]; y6_imag = y_im_q[6]; y7_real = y_re_q[7]; y7_imag = y_im_q[7];
   end
endmodule

// File: tb/tb_fft.sv
// tb_fft: table-driven spectral vectors plus a randomized stream checked against a
// floating-point DFT of the quantised inputs, and a mid-stream asynchronous reset.
module tb_fft;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] x_re [8], x_im [8];
   logic [11:0] y_re [8], y_im [8];
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      int xr [8];
      int xi [8];
      int yr [8];
      int yi [8];
      int tol;
   } vec_t;

   vec_t tbl [5];
   int   rr [100][8];
   int   ri [100][8];

   always #5 clk = ~clk;

   fft #(.N(8), .INPUT_WORD_WIDTH(12), .INPUT_INTEGER_WIDTH(3),
         .OUTPUT_WORD_WIDTH(12), .OUTPUT_INTEGER_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .x0_real(x_re[0]), .x0_imag(x_im[0]), .x1_real(x_re[1]), .x1_imag(x_im[1]),
      .x2_real(x_re[2]), .x2_imag(x_im[2]), .x3_real(x_re[3]), .x3_imag(x_im[3]),
      .x4_real(x_re[4]), .x4_imag(x_im[4]), .x5_real(x_re[5]), .x5_imag(x_im[5]),
      .x6_real(x_re[6]), .x6_imag(x_im[6]), .x7_real(x_re[7]), .x7_imag(x_im[7]),
      .y0_real(y_re[0]), .y0_imag(y_im[0]), .y1_real(y_re[1]), .y1_imag(y_im[1]),
      .y2_real(y_re[2]), .y2_imag(y_im[2]), .y3_real(y_re[3]), .y3_imag(y_im[3]),
      .y4_real(y_re[4]), .y4_imag(y_im[4]), .y5_real(y_re[5]), .y5_imag(y_im[5]),
      .y6_real(y_re[6]), .y6_imag(y_im[6]), .y7_real(y_re[7]), .y7_imag(y_im[7])
   );

   task automatic chk(input string nm, input int act, input real exp, input int tol);
      real diff;
      tests++;
      diff = real'(act) - exp;
      if (diff < 0.0) diff = -diff;
      if (diff > real'(tol)) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0.2f (+/-%0d)", nm, act, exp, tol);
      end
   endtask

   task automatic drive(input int r [8], input int i [8]);
      for (int k = 0; k < 8; k++) begin
         x_re[k] = 12'(r[k]);
         x_im[k] = 12'(i[k]);
      end
   endtask

   task automatic chk_all(input string tag, input int er [8], input int ei [8], input int tol);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s y%0d_real", tag, k), int'($signed(y_re[k])), real'(er[k]), tol);
         chk($sformatf("%s y%0d_imag", tag, k), int'($signed(y_im[k])), real'(ei[k]), tol);
      end
   endtask

   // Exact DFT of the quantised inputs, expressed in output LSBs (Q3.9 -> Q5.7 is /4).
   task automatic model(input int r [8], input int i [8], input int k, output real er, output real ei);
      real th;
      er = 0.0;
      ei = 0.0;
      for (int n = 0; n < 8; n++) begin
         th = 2.0 * 3.14159265358979 * real'(n * k) / 8.0;
         er += real'(r[n]) * $cos(th) + real'(i[n]) * $sin(th);
         ei += real'(i[n]) * $cos(th) - real'(r[n]) * $sin(th);
      end
      er = er / 4.0;
      ei = ei / 4.0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int zr [8], zi [8], imp [8], cr [8], ci [8], rv [8], iv [8];
      real er, ei;

      for (int k = 0; k < 8; k++) begin
         zr[k] = 0; zi[k] = 0; imp[k] = 128;
      end
      for (int v = 0; v < 5; v++) begin
         tbl[v].xr = zr; tbl[v].xi = zi; tbl[v].yr = zr; tbl[v].yi = zi; tbl[v].tol = 3;
      end
      // impulse
      tbl[0].xr[0] = 512; tbl[0].yr = imp; tbl[0].tol = 0;
      // DC
      for (int k = 0; k < 8; k++) tbl[1].xr[k] = 512;
      tbl[1].yr[0] = 1024;
      // Nyquist
      for (int k = 0; k < 8; k++) tbl[2].xr[k] = (k % 2 == 0) ? 512 : -512;
      tbl[2].yr[4] = 1024;
      // tone at bin 1
      tbl[3].xr = '{512, 362, 0, -362, -512, -362, 0, 362};
      tbl[3].yr[1] = 512; tbl[3].yr[7] = 512;
      // overflow of bin 0
      for (int k = 0; k < 8; k++) tbl[4].xr[k] = 2047;
`ifdef FFT_SAT_EN
      tbl[4].yr[0] = 2047;
`else
      tbl[4].yr[0] = -2;
`endif
      tbl[4].tol = 0;

      rst_n = 1'b0;
      drive(zr, zi);
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", zr, zi, 0);
      #1 rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         @(posedge clk); #1;
         drive(tbl[v].xr, tbl[v].xi);
         repeat (3) @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", v), tbl[v].yr, tbl[v].yi, tbl[v].tol);
         @(posedge clk); #1;
         chk_all($sformatf("vec%0d held", v), tbl[v].yr, tbl[v].yi, tbl[v].tol);
      end

      // Random stream, one vector per cycle; first half small-range, second half full-range.
      for (int v = 0; v < 100; v++) begin
         for (int n = 0; n < 8; n++) begin
            if (v < 50) begin
               rr[v][n] = int'($urandom_range(0, 1023)) - 512;
               ri[v][n] = int'($urandom_range(0, 1023)) - 512;
            end else begin
               rr[v][n] = int'($urandom_range(0, 4095)) - 2048;
               ri[v][n] = int'($urandom_range(0, 4095)) - 2048;
            end
         end
      end
      for (int j = 0; j < 103; j++) begin
         @(posedge clk); #1;
         if (j >= 3) begin
            cr = rr[j-3];
            ci = ri[j-3];
            for (int k = 0; k < 8; k++) begin
               model(cr, ci, k, er, ei);
               if (er < 2040.0 && er > -2040.0)
                  chk($sformatf("rand%0d y%0d_real", j - 3, k), int'($signed(y_re[k])), er, 3);
               if (ei < 2040.0 && ei > -2040.0)
                  chk($sformatf("rand%0d y%0d_imag", j - 3, k), int'($signed(y_im[k])), ei, 3);
            end
         end
         if (j < 100) begin
            rv = rr[j];
            iv = ri[j];
            drive(rv, iv);
         end
      end

      // Mid-stream reset: outputs clear without an edge, then an impulse shows exact latency.
      for (int j = 0; j < 5; j++) begin
         @(posedge clk); #1;
         rv = rr[j];
         iv = ri[j];
         drive(rv, iv);
      end
      #2 rst_n = 1'b0;
      #1;
      chk_all("async reset", zr, zi, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      drive(tbl[0].xr, tbl[0].xi);
      repeat (2) @(posedge clk);
      #1;
      chk_all("post-reset edge2", zr, zi, 0);
      @(posedge clk); #1;
      chk_all("post-reset edge3", imp, zi, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
